// File: rtl/suma_distancia_pkg.sv
// suma_distancia_pkg
// Shared definitions for the fixed-point distance accumulator:
//   - estado_t : control FSM encodings (IDLE, DIVIDE, ACUM)
//   - calc_qw  : quotient width derivation (integer bits + fractional bits)
package suma_distancia_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      ACUM   = 2'd2
   } estado_t;

   // Quotient width: the numerator is pre-shifted by bits_frac, so the
   // quotient needs the full numerator width plus the fractional bits.
   function automatic int calc_qw(input int ancho_entrada, input int bits_frac);
      return ancho_entrada + bits_frac;
   endfunction

endpackage

// File: rtl/suma_distancia_if.sv
// suma_distancia_if
// Sample handshake and result bus of suma_distancia.
//   master : sample source / result consumer (drives validar, numero1,
//            numero2, limpiar)
//   slave  : the accumulator (drives recibido, sumatotal, listo, div_cero,
//            desborde)
interface suma_distancia_if #(
   parameter int ANCHO_ENTRADA = 32,
   parameter int ANCHO_TOTAL   = 32
);
   logic                     validar;
   logic                     recibido;
   logic [ANCHO_ENTRADA-1:0] numero1;
   logic [ANCHO_ENTRADA-1:0] numero2;
   logic                     limpiar;
   logic [ANCHO_TOTAL-1:0]   sumatotal;
   logic                     listo;
   logic                     div_cero;
   logic                     desborde;

   modport master (
      output validar, numero1, numero2, limpiar,
      input  recibido, sumatotal, listo, div_cero, desborde
   );

   modport slave (
      input  validar, numero1, numero2, limpiar,
      output recibido, sumatotal, listo, div_cero, desborde
   );
endinterface

// File: rtl/divisor_secuencial.sv
// divisor_secuencial
// Restoring divider, one quotient bit per cycle, MSB first.
// Computes floor((dividendo << BITS_FRAC) / divisor) over QW cycles.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   start        : load operands (divisor must be nonzero)
//   dividendo    : numerator, ANCHO_ENTRADA bits
//   divisor      : denominator, ANCHO_ENTRADA bits
//   busy         : a division is in progress
//   done         : high during the last quotient-bit cycle
//   cociente     : quotient, valid once busy has dropped
module divisor_secuencial
   import suma_distancia_pkg::*;
#(
   parameter int ANCHO_ENTRADA = 32,
   parameter int BITS_FRAC     = 8
) (
   input  logic                                           clock,
   input  logic                                           reset,
   input  logic                                           start,
   input  logic [ANCHO_ENTRADA-1:0]                       dividendo,
   input  logic [ANCHO_ENTRADA-1:0]                       divisor,
   output logic                                           busy,
   output logic                                           done,
   output logic [calc_qw(ANCHO_ENTRADA, BITS_FRAC)-1:0]   cociente
);
   localparam int QW = calc_qw(ANCHO_ENTRADA, BITS_FRAC);
   localparam int CW = $clog2(QW);

   // The shifted numerator is consumed from the top while quotient bits
   // enter at the bottom, so after QW steps this register holds q.
   logic [QW-1:0]            acum_q;
   logic [ANCHO_ENTRADA:0]   resto;
   logic [ANCHO_ENTRADA-1:0] dsr;
   logic [CW-1:0]            cuenta;
   logic                     activo;

   logic [ANCHO_ENTRADA:0]   resto_sh;
   logic [ANCHO_ENTRADA+1:0] prueba;

   assign resto_sh = {resto[ANCHO_ENTRADA-1:0], acum_q[QW-1]};
   // Extra top bit acts as the borrow of the trial subtraction.
   assign prueba   = {1'b0, resto_sh} - {2'b00, dsr};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acum_q <= '0;
         resto  <= '0;
         dsr    <= '0;
         cuenta <= '0;
         activo <= 1'b0;
      end else if (start) begin
         acum_q <= QW'(dividendo) << BITS_FRAC;
         resto  <= '0;
         dsr    <= divisor;
         cuenta <= CW'(QW - 1);
         activo <= 1'b1;
      end else if (activo) begin
         if (prueba[ANCHO_ENTRADA+1]) begin
            resto  <= resto_sh;
            acum_q <= {acum_q[QW-2:0], 1'b0};
         end else begin
            resto  <= prueba[ANCHO_ENTRADA:0];
            acum_q <= {acum_q[QW-2:0], 1'b1};
         end
         if (cuenta == '0) activo <= 1'b0;
         else              cuenta <= cuenta - 1'b1;
      end
   end

   assign busy     = activo;
   assign done     = activo && (cuenta == '0);
   assign cociente = acum_q;

endmodule

// File: rtl/suma_distancia.sv
// suma_distancia
// Fixed-point distance accumulator: accepts (numero1, numero2) samples,
// divides them in divisor_secuencial to a Q-format quotient with BITS_FRAC
// fractional bits, and adds the quotient into a running total.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : validar/recibido handshake, numero1/numero2 operands,
//                  limpiar clear, sumatotal, listo pulse, div_cero and
//                  desborde sticky flags
// Build option: SUMA_SATURACION_EN saturates the total at all ones on
// overflow; otherwise the total wraps modulo 2^ANCHO_TOTAL.
module suma_distancia
   import suma_distancia_pkg::*;
#(
   parameter int ANCHO_ENTRADA = 32,
   parameter int BITS_FRAC     = 8,
   parameter int ANCHO_TOTAL   = 32
) (
   input  logic            clock,
   input  logic            reset,
   suma_distancia_if.slave bus
);
   localparam int QW = calc_qw(ANCHO_ENTRADA, BITS_FRAC);

   estado_t estado, siguiente;

   logic                   acepta;
   logic                   divisor_nulo;
   logic                   es_cero;
   logic                   div_start, div_busy, div_done;
   logic [QW-1:0]          cociente;

   logic [ANCHO_TOTAL-1:0] total;
   logic                   listo_r, div_cero_r, desborde_r;

   logic [QW-1:0]          q_sel;
   logic [ANCHO_TOTAL-1:0] q_trunc;
   logic                   q_alto;
   logic [ANCHO_TOTAL:0]   suma;
   logic                   ovf;
   logic [ANCHO_TOTAL-1:0] nuevo;

   assign bus.recibido = (estado == IDLE);
   assign acepta       = bus.validar && bus.recibido;
   assign divisor_nulo = (bus.numero2 == '0);
   assign div_start    = acepta && !divisor_nulo;

   divisor_secuencial #(
      .ANCHO_ENTRADA (ANCHO_ENTRADA),
      .BITS_FRAC     (BITS_FRAC)
   ) u_div (
      .clock     (clock),
      .reset     (reset),
      .start     (div_start),
      .dividendo (bus.numero1),
      .divisor   (bus.numero2),
      .busy      (div_busy),
      .done      (div_done),
      .cociente  (cociente)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) estado <= IDLE;
      else       estado <= siguiente;
   end

   always_comb begin
      siguiente = estado;
      case (estado)
         IDLE:    if (acepta) siguiente = divisor_nulo ? ACUM : DIVIDE;
         // !div_busy only guards against a divider that is already idle.
         DIVIDE:  if (div_done || !div_busy) siguiente = ACUM;
         ACUM:    siguiente = IDLE;
         default: siguiente = IDLE;
      endcase
   end

   // A zero divisor contributes nothing, so the add path needs no special
   // case: the sum equals the total and cannot overflow.
   always_comb begin
      q_sel   = es_cero ? '0 : cociente;
      q_alto  = |(q_sel >> ANCHO_TOTAL);
      q_trunc = ANCHO_TOTAL'(q_sel);
      suma    = {1'b0, total} + {1'b0, q_trunc};
      ovf     = q_alto | suma[ANCHO_TOTAL];
`ifdef SUMA_SATURACION_EN
      nuevo   = ovf ? '1 : suma[ANCHO_TOTAL-1:0];
`else
      nuevo   = suma[ANCHO_TOTAL-1:0];
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         es_cero    <= 1'b0;
         total      <= '0;
         listo_r    <= 1'b0;
         div_cero_r <= 1'b0;
         desborde_r <= 1'b0;
      end else begin
         listo_r <= (estado == ACUM);
         if (acepta) es_cero <= divisor_nulo;
         // limpiar takes priority over the pending add; the quotient is lost.
         if (bus.limpiar) begin
            total      <= '0;
            div_cero_r <= 1'b0;
            desborde_r <= 1'b0;
         end else if (estado == ACUM) begin
            total <= nuevo;
            if (es_cero) div_cero_r <= 1'b1;
            if (ovf)     desborde_r <= 1'b1;
         end
      end
   end

   assign bus.sumatotal = total;
   assign bus.listo     = listo_r;
   assign bus.div_cero  = div_cero_r;
   assign bus.desborde  = desborde_r;

endmodule

// File: tb/tb_suma_distancia.sv
// tb_suma_distancia
// Directed bench for suma_distancia: a default instance (32-bit total) and a
// 16-bit-total instance for the overflow cases.
module tb_suma_distancia;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   suma_distancia_if #(.ANCHO_ENTRADA(32), .ANCHO_TOTAL(32)) bus_a ();
   suma_distancia_if #(.ANCHO_ENTRADA(32), .ANCHO_TOTAL(16)) bus_b ();

   suma_distancia #(.ANCHO_ENTRADA(32), .BITS_FRAC(8), .ANCHO_TOTAL(32)) dut_a (
      .clock (clock),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   suma_distancia #(.ANCHO_ENTRADA(32), .BITS_FRAC(8), .ANCHO_TOTAL(16)) dut_b (
      .clock (clock),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one sample, wait for its accept, then count edges until listo.
   // rdy_tras is recibido one half-cycle after the accept edge.
   task automatic enviar(input bit sel, input logic [31:0] n1, input logic [31:0] n2,
                         output int lat, output bit rdy_tras);
      int espera;
      @(negedge clock);
      if (sel) begin
         bus_b.validar = 1'b1; bus_b.numero1 = n1; bus_b.numero2 = n2;
      end else begin
         bus_a.validar = 1'b1; bus_a.numero1 = n1; bus_a.numero2 = n2;
      end
      espera = 0;
      while (!(sel ? bus_b.recibido : bus_a.recibido) && espera < 100) begin
         @(negedge clock);
         espera++;
      end
      @(posedge clock);
      @(negedge clock);
      bus_a.validar = 1'b0;
      bus_b.validar = 1'b0;
      rdy_tras = sel ? bus_b.recibido : bus_a.recibido;
      lat = 0;
      do begin
         @(posedge clock);
         #1;
         lat++;
      end while (!(sel ? bus_b.listo : bus_a.listo) && lat < 100);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;
      bit rdy;
      int acc;

      bus_a.validar = 1'b0; bus_a.numero1 = '0; bus_a.numero2 = '0; bus_a.limpiar = 1'b0;
      bus_b.validar = 1'b0; bus_b.numero1 = '0; bus_b.numero2 = '0; bus_b.limpiar = 1'b0;

      // Reset state
      #1;
      chk("rst_recibido", bus_a.recibido, 1);
      chk("rst_sumatotal", bus_a.sumatotal, 0);
      chk("rst_listo", bus_a.listo, 0);
      chk("rst_div_cero", bus_a.div_cero, 0);
      chk("rst_desborde", bus_a.desborde, 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // 10/4 -> 2560/4 = 640
      enviar(0, 10, 4, lat, rdy);
      chk("lat_10_4", lat, 41);
      chk("recibido_div", rdy, 0);
      chk("sum_10_4", bus_a.sumatotal, 640);
      @(posedge clock); #1;
      chk("listo_fall", bus_a.listo, 0);

      // 3/3 -> 256, total 896
      enviar(0, 3, 3, lat, rdy);
      chk("lat_3_3", lat, 41);
      chk("sum_3_3", bus_a.sumatotal, 896);

      // validar held high: accepts at edges 0, 42, 84 of a 126-edge window
      @(negedge clock);
      bus_a.validar = 1'b1; bus_a.numero1 = 1; bus_a.numero2 = 1;
      acc = 0;
      for (int i = 0; i < 126; i++) begin
         if (bus_a.recibido) acc++;
         @(negedge clock);
      end
      bus_a.validar = 1'b0;
      chk("accepts_126", acc, 3);
      chk("sum_stream", bus_a.sumatotal, 1664);

      // zero divisor
      enviar(0, 5, 0, lat, rdy);
      chk("lat_zero", lat, 1);
      chk("sum_zero", bus_a.sumatotal, 1664);
      chk("div_cero_set", bus_a.div_cero, 1);
      repeat (3) @(negedge clock);
      chk("div_cero_sticky", bus_a.div_cero, 1);
      bus_a.limpiar = 1'b1;
      @(negedge clock);
      bus_a.limpiar = 1'b0;
      chk("clr_sum", bus_a.sumatotal, 0);
      chk("clr_div_cero", bus_a.div_cero, 0);

      // limpiar on the ACUM cycle of 8/2 with total 0x400
      enviar(0, 4, 1, lat, rdy);
      chk("sum_4_1", bus_a.sumatotal, 32'h400);
      enviar(0, 7, 0, lat, rdy);
      chk("div_cero_pre", bus_a.div_cero, 1);
      @(negedge clock);
      bus_a.validar = 1'b1; bus_a.numero1 = 8; bus_a.numero2 = 2;
      @(posedge clock);
      @(negedge clock);
      bus_a.validar = 1'b0;
      repeat (40) @(posedge clock);
      @(negedge clock);
      bus_a.limpiar = 1'b1;
      @(posedge clock); #1;
      chk("acum_clr_listo", bus_a.listo, 1);
      chk("acum_clr_sum", bus_a.sumatotal, 0);
      chk("acum_clr_div_cero", bus_a.div_cero, 0);
      @(negedge clock);
      bus_a.limpiar = 1'b0;

      // reset 10 cycles into a division
      enviar(0, 1, 1, lat, rdy);
      chk("sum_pre_rst", bus_a.sumatotal, 256);
      @(negedge clock);
      bus_a.validar = 1'b1; bus_a.numero1 = 9; bus_a.numero2 = 3;
      @(posedge clock);
      @(negedge clock);
      bus_a.validar = 1'b0;
      repeat (10) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("mid_rst_recibido", bus_a.recibido, 1);
      chk("mid_rst_sum", bus_a.sumatotal, 0);
      chk("mid_rst_listo", bus_a.listo, 0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      chk("post_rst_recibido", bus_a.recibido, 1);
      enviar(0, 1, 1, lat, rdy);
      chk("post_rst_lat", lat, 41);
      chk("post_rst_sum", bus_a.sumatotal, 256);

      // 16-bit total: 0xFF00 then +0x100 overflows
      enviar(1, 255, 1, lat, rdy);
      chk("b_sum_ff00", bus_b.sumatotal, 16'hFF00);
      chk("b_desborde_pre", bus_b.desborde, 0);
      enviar(1, 1, 1, lat, rdy);
`ifdef SUMA_SATURACION_EN
      chk("b_sum_ovf", bus_b.sumatotal, 16'hFFFF);
`else
      chk("b_sum_ovf", bus_b.sumatotal, 16'h0000);
`endif
      chk("b_desborde", bus_b.desborde, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
